// File: rtl/sipo_pkg.sv
// Shared types for the serial-to-parallel deserializer.
// The SIPO_PARITY_EN macro adds the PARITY state and enables even-parity checking.
package sipo_pkg;

`ifdef SIPO_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} sipo_state_t;
`else
  localparam bit PARITY_EN = 1'b0;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} sipo_state_t;
`endif

endpackage

// File: rtl/sipo_bit_counter.sv
// Counts accepted data bits. done flags the LIMIT-th increment, and the count wraps to 0 on that increment.
// clr restarts the count. If clr and inc are both asserted, this cycle's bit counts as the first bit.
module sipo_bit_counter #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic done
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  assign done = inc && (count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr || done) begin
      count <= (inc && !done) ? CW'(1) : '0;
    end else if (inc) begin
      count <= count + CW'(1);
    end
  end
endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer. It takes bits MSB first and presents each word through a
// valid/ready handshake. Defining SIPO_PARITY_EN adds a trailing even-parity bit to every word.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  serial_in,
  input  logic                  serial_valid,
  output logic                  serial_ready,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] parallel_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  parity_err
);
  sipo_state_t           state, next_state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  accept, handshake, data_done, parity_take, word_done, cnt_clr, cnt_inc;
  logic [DATA_WIDTH-1:0] next_word;
  logic                  next_err;

  // Handshakes: a bit moves when serial_valid && serial_ready, and a word moves when
  // word_valid && word_ready. In HOLD a new bit is taken only in a cycle that frees the word.
  assign serial_ready = (state != HOLD) || word_ready;
  assign accept       = serial_valid && serial_ready && !abort;
  assign handshake    = word_valid && word_ready;

`ifdef SIPO_PARITY_EN
  assign parity_take = accept && (state == PARITY);
`else
  assign parity_take = 1'b0;
`endif

  assign cnt_inc   = accept && !parity_take;
  assign cnt_clr   = abort || ((state == HOLD) && word_ready);
  assign word_done = PARITY_EN ? parity_take : data_done;
  assign next_word = PARITY_EN ? shift_reg : {shift_reg[DATA_WIDTH-2:0], serial_in};
  assign next_err  = PARITY_EN && ((^shift_reg) ^ serial_in);

  sipo_bit_counter #(.LIMIT(DATA_WIDTH)) u_bit_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .done  (data_done)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (accept) next_state = SHIFT;
`ifdef SIPO_PARITY_EN
      SHIFT:  if (data_done) next_state = PARITY;
      PARITY: if (parity_take) next_state = HOLD;
`else
      SHIFT: if (data_done) next_state = HOLD;
`endif
      HOLD:  if (handshake) next_state = accept ? SHIFT : IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg    <= '0;
      parallel_out <= '0;
      word_valid   <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      if (cnt_inc) shift_reg <= {shift_reg[DATA_WIDTH-2:0], serial_in};
      // parallel_out keeps its last word when the word is aborted or taken.
      if (abort) begin
        word_valid <= 1'b0;
        parity_err <= 1'b0;
      end else if (word_done) begin
        parallel_out <= next_word;
        word_valid   <= 1'b1;
        parity_err   <= next_err;
      end else if (handshake) begin
        word_valid <= 1'b0;
        parity_err <= 1'b0;
      end
    end
  end
endmodule
